// File: rtl/csr_trap_unit_pkg.sv
// Shared constants for the user-mode trap unit: CSR map, ustatus bits, cause codes, FSM states.
package csr_trap_unit_pkg;

  localparam logic [11:0] CSR_USTATUS = 12'h000;
  localparam logic [11:0] CSR_UTVEC   = 12'h005;
  localparam logic [11:0] CSR_UEPC    = 12'h041;
  localparam logic [11:0] CSR_UCAUSE  = 12'h042;

  localparam int unsigned USTATUS_UIE  = 0;
  localparam int unsigned USTATUS_UPIE = 4;

  localparam int unsigned CAUSE_ECALL    = 8;
  localparam int unsigned IRQ_CAUSE_BASE = 16;

  typedef enum logic [0:0] {
    StIdle     = 1'b0,
    StRedirect = 1'b1
  } trap_state_e;

endpackage

// File: rtl/csr_trap_unit_irq_pending.sv
// Per-line irq synchronizer, rising-edge detect, sticky pending latch and
// lowest-index-first priority encoder.
module csr_trap_unit_irq_pending #(
  parameter int unsigned NUM_IRQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_clear,
  output logic               o_any_pending,
  output logic [IDX_W-1:0]   o_idx
);

  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;
  logic [NUM_IRQ-1:0] r_sync_prev;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] w_rise;

  assign w_rise = r_sync2 & ~r_sync_prev;

  // A fresh edge on the same cycle its line is cleared re-arms the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sync_prev <= '0;
      r_pending   <= '0;
    end else begin
      r_sync1     <= i_irq;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
      r_pending   <= (r_pending & ~i_clear) | w_rise;
    end
  end

  always_comb begin
    o_idx = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (r_pending[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_any_pending = |r_pending;

endmodule

// File: rtl/csr_trap_unit.sv
// User-mode trap CSRs (ustatus/utvec/uepc/ucause) with ecall/uret/interrupt handling
// at commit and a registered one-cycle redirect + flush toward fetch.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      NUM_IRQ    = 3,
  parameter logic [WIDTH-1:0] TVEC_RESET = 32'h0000_0200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               commit_valid,
  input  logic [WIDTH-1:0]   commit_pc,
  input  logic               ecall,
  input  logic               uret,
  input  logic               CSRRW,
  input  logic               CSRRSI,
  input  logic               CSRRCI,
  input  logic [11:0]        csr_addr,
  input  logic [WIDTH-1:0]   csr_src,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [WIDTH-1:0]   csr_rdata,
  output logic               redirect,
  output logic [WIDTH-1:0]   redirect_pc,
  output logic               flush,
  output logic [NUM_IRQ-1:0] irq_ack
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  trap_state_e        r_state, w_state_next;
  logic               r_uie, w_uie_next;
  logic               r_upie, w_upie_next;
  logic [WIDTH-1:0]   r_utvec, w_utvec_next;
  logic [WIDTH-1:0]   r_uepc, w_uepc_next;
  logic [WIDTH-1:0]   r_ucause, w_ucause_next;
  logic [WIDTH-1:0]   r_redirect_pc, w_redirect_pc_next;
  logic [NUM_IRQ-1:0] r_irq_ack, w_irq_ack_next;
  logic [NUM_IRQ-1:0] w_irq_clear;

  logic               w_any_pending;
  logic [IDX_W-1:0]   w_irq_idx;
  logic               w_commit, w_take_ecall, w_take_uret, w_take_irq, w_csr_we;
  logic [WIDTH-1:0]   w_ustatus, w_csr_old, w_zimm, w_csr_wdata;

  csr_trap_unit_irq_pending #(
    .NUM_IRQ(NUM_IRQ),
    .IDX_W  (IDX_W)
  ) u_irq_pending (
    .clk          (clk),
    .rst          (rst),
    .i_irq        (irq),
    .i_clear      (w_irq_clear),
    .o_any_pending(w_any_pending),
    .o_idx        (w_irq_idx)
  );

  always_comb begin
    w_ustatus               = '0;
    w_ustatus[USTATUS_UIE]  = r_uie;
    w_ustatus[USTATUS_UPIE] = r_upie;
  end

  always_comb begin
    w_csr_old = '0;
    case (csr_addr)
      CSR_USTATUS: w_csr_old = w_ustatus;
      CSR_UTVEC:   w_csr_old = r_utvec;
      CSR_UEPC:    w_csr_old = r_uepc;
      CSR_UCAUSE:  w_csr_old = r_ucause;
      default:     w_csr_old = '0;
    endcase
  end

  assign csr_rdata = w_csr_old;
  assign w_zimm    = WIDTH'(csr_src[4:0]);

  // Sync events outrank interrupts; a taken interrupt suppresses the CSR write.
  assign w_commit     = (r_state == StIdle) && commit_valid;
  assign w_take_ecall = w_commit && ecall;
  assign w_take_uret  = w_commit && !ecall && uret;
  assign w_take_irq   = w_commit && !ecall && !uret && r_uie && w_any_pending;
  assign w_csr_we     = w_commit && !ecall && !uret && !w_take_irq && (CSRRW || CSRRSI || CSRRCI);

  always_comb begin
    if (CSRRW)       w_csr_wdata = csr_src;
    else if (CSRRSI) w_csr_wdata = w_csr_old | w_zimm;
    else             w_csr_wdata = w_csr_old & ~w_zimm;
  end

  always_comb begin
    w_uie_next         = r_uie;
    w_upie_next        = r_upie;
    w_utvec_next       = r_utvec;
    w_uepc_next        = r_uepc;
    w_ucause_next      = r_ucause;
    w_redirect_pc_next = r_redirect_pc;
    w_irq_ack_next     = '0;
    w_irq_clear        = '0;
    if (w_take_ecall) begin
      w_uepc_next        = commit_pc & ~WIDTH'(3);
      w_ucause_next      = WIDTH'(CAUSE_ECALL);
      w_upie_next        = r_uie;
      w_uie_next         = 1'b0;
      w_redirect_pc_next = r_utvec;
    end else if (w_take_uret) begin
      w_uie_next         = r_upie;
      w_upie_next        = 1'b1;
      w_redirect_pc_next = r_uepc;
    end else if (w_take_irq) begin
      w_uepc_next        = commit_pc & ~WIDTH'(3);
      w_ucause_next      = {1'b1, (WIDTH-1)'(IRQ_CAUSE_BASE + 32'(w_irq_idx))};
      w_upie_next        = r_uie;
      w_uie_next         = 1'b0;
      w_irq_clear        = NUM_IRQ'(1) << w_irq_idx;
      w_irq_ack_next     = NUM_IRQ'(1) << w_irq_idx;
      w_redirect_pc_next = r_utvec;
    end else if (w_csr_we) begin
      case (csr_addr)
        CSR_USTATUS: begin
          w_uie_next  = w_csr_wdata[USTATUS_UIE];
          w_upie_next = w_csr_wdata[USTATUS_UPIE];
        end
        CSR_UTVEC:  w_utvec_next  = w_csr_wdata;
        CSR_UEPC:   w_uepc_next   = w_csr_wdata & ~WIDTH'(3);
        CSR_UCAUSE: w_ucause_next = w_csr_wdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:     if (w_take_ecall || w_take_uret || w_take_irq) w_state_next = StRedirect;
      StRedirect: w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_uie         <= 1'b0;
      r_upie        <= 1'b0;
      r_utvec       <= TVEC_RESET;
      r_uepc        <= '0;
      r_ucause      <= '0;
      r_redirect_pc <= '0;
      r_irq_ack     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_uie         <= w_uie_next;
      r_upie        <= w_upie_next;
      r_utvec       <= w_utvec_next;
      r_uepc        <= w_uepc_next;
      r_ucause      <= w_ucause_next;
      r_redirect_pc <= w_redirect_pc_next;
      r_irq_ack     <= w_irq_ack_next;
    end
  end

  always_comb begin
    redirect    = (r_state == StRedirect);
    flush       = (r_state == StRedirect);
    redirect_pc = r_redirect_pc;
    irq_ack     = r_irq_ack;
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: expected redirects are queued at commit and
// popped by a negedge monitor; CSR state is read back through csr_rdata.
module tb_csr_trap_unit;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NUM_IRQ = 3;

  localparam logic [4:0] F_NONE  = 5'b00000;
  localparam logic [4:0] F_ECALL = 5'b10000;
  localparam logic [4:0] F_URET  = 5'b01000;
  localparam logic [4:0] F_RW    = 5'b00100;
  localparam logic [4:0] F_RSI   = 5'b00010;
  localparam logic [4:0] F_RCI   = 5'b00001;

  logic               clk = 1'b0;
  logic               rst;
  logic               commit_valid;
  logic [WIDTH-1:0]   commit_pc;
  logic               ecall, uret, CSRRW, CSRRSI, CSRRCI;
  logic [11:0]        csr_addr;
  logic [WIDTH-1:0]   csr_src;
  logic [NUM_IRQ-1:0] irq;
  logic [WIDTH-1:0]   csr_rdata;
  logic               redirect;
  logic [WIDTH-1:0]   redirect_pc;
  logic               flush;
  logic [NUM_IRQ-1:0] irq_ack;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  ack;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic prev_red = 1'b0;

  always #5 clk = ~clk;

  csr_trap_unit #(
    .WIDTH     (WIDTH),
    .NUM_IRQ   (NUM_IRQ),
    .TVEC_RESET(32'h0000_0200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .commit_valid(commit_valid),
    .commit_pc   (commit_pc),
    .ecall       (ecall),
    .uret        (uret),
    .CSRRW       (CSRRW),
    .CSRRSI      (CSRRSI),
    .CSRRCI      (CSRRCI),
    .csr_addr    (csr_addr),
    .csr_src     (csr_src),
    .irq         (irq),
    .csr_rdata   (csr_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush),
    .irq_ack     (irq_ack)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_val("flush_eq_redirect", 32'(flush), 32'(redirect));
      if (redirect) begin
        check_val("redirect_single_pulse", 32'(prev_red), 32'd0);
        if (sb.size() == 0) begin
          check_val("redirect_unexpected", 32'(redirect), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check_val("redirect_pc", redirect_pc, mon_e.pc);
          check_val("irq_ack", 32'(irq_ack), 32'(mon_e.ack));
        end
      end else begin
        check_val("irq_ack_idle", 32'(irq_ack), 32'd0);
      end
      prev_red <= redirect;
    end else begin
      prev_red <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_commit(input logic [31:0] pc, input logic [4:0] f,
                           input logic [11:0] addr, input logic [31:0] src);
    commit_valid = 1'b1;
    commit_pc    = pc;
    {ecall, uret, CSRRW, CSRRSI, CSRRCI} = f;
    csr_addr     = addr;
    csr_src      = src;
    step();
    commit_valid = 1'b0;
    {ecall, uret, CSRRW, CSRRSI, CSRRCI} = 5'b0;
  endtask

  task automatic expect_redirect(input logic [31:0] pc, input logic [2:0] ack);
    exp_t e;
    e.pc  = pc;
    e.ack = ack;
    sb.push_back(e);
  endtask

  // Bounded wait for the monitor to consume every queued redirect.
  task automatic drain(input string tag);
    step();
    for (int i = 0; i < 4 && sb.size() != 0; i++) step();
    check_val(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #1;
    check_val(tag, csr_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=running expected=finished");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    commit_valid = 1'b0;
    commit_pc    = '0;
    {ecall, uret, CSRRW, CSRRSI, CSRRCI} = 5'b0;
    csr_addr     = '0;
    csr_src      = '0;
    irq          = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_redirect", 32'(redirect), 32'd0);
    check_val("rst_flush", 32'(flush), 32'd0);
    check_val("rst_irq_ack", 32'(irq_ack), 32'd0);
    check_val("rst_redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;
    rd("rst_utvec", 12'h005, 32'h200);
    rd("rst_ustatus", 12'h000, 32'h0);
    rd("rst_uepc", 12'h041, 32'h0);
    step();
    rd("rst_ucause", 12'h042, 32'h0);
    rd("rst_unmapped", 12'h123, 32'h0);
    step();

    // Enable UIE; rdata shows the pre-write value during the commit.
    commit_valid = 1'b1;
    commit_pc    = 32'h3c;
    CSRRSI       = 1'b1;
    csr_addr     = 12'h000;
    csr_src      = 32'h1;
    #1;
    check_val("rdata_prewrite", csr_rdata, 32'h0);
    step();
    commit_valid = 1'b0;
    CSRRSI       = 1'b0;
    rd("ustatus_uie_set", 12'h000, 32'h1);

    expect_redirect(32'h200, 3'b000);
    do_commit(32'h40, F_ECALL, 12'h000, 32'h0);
    drain("ecall_drain");
    rd("ecall_uepc", 12'h041, 32'h40);
    rd("ecall_ucause", 12'h042, 32'h8);
    rd("ecall_ustatus", 12'h000, 32'h10);

    // uret, followed by a commit in the REDIRECT cycle that must be ignored.
    expect_redirect(32'h40, 3'b000);
    do_commit(32'h100, F_URET, 12'h000, 32'h0);
    do_commit(32'h300, F_ECALL | F_RW, 12'h005, 32'h1234);
    drain("uret_drain");
    rd("uret_ustatus", 12'h000, 32'h11);
    rd("redirect_cycle_uepc", 12'h041, 32'h40);
    rd("redirect_cycle_utvec", 12'h005, 32'h200);
    step();

    do_commit(32'h104, F_RCI, 12'h000, 32'h1);
    rd("csrrci_ustatus", 12'h000, 32'h10);
    do_commit(32'h108, F_RW, 12'h041, 32'h123);
    rd("uepc_low_bits", 12'h041, 32'h120);
    do_commit(32'h10c, F_RW, 12'h7c0, 32'hffff);
    rd("unmapped_write", 12'h7c0, 32'h0);

    // irq[1] while UIE=0: nothing happens until UIE is set by CSRRSI.
    irq[1] = 1'b1;
    idle(5);
    do_commit(32'h80, F_NONE, 12'h000, 32'h0);
    irq[1] = 1'b0;
    idle(2);
    do_commit(32'h84, F_RSI, 12'h000, 32'h1);
    expect_redirect(32'h200, 3'b010);
    do_commit(32'h88, F_RW, 12'h005, 32'h999);
    drain("irq1_drain");
    rd("irq1_ucause", 12'h042, 32'h8000_0011);
    rd("irq1_uepc", 12'h041, 32'h88);
    rd("irq1_ustatus", 12'h000, 32'h10);
    step();
    rd("irq1_suppressed_write", 12'h005, 32'h200);

    expect_redirect(32'h88, 3'b000);
    do_commit(32'h200, F_URET, 12'h000, 32'h0);
    drain("uret2_drain");
    rd("uret2_ustatus", 12'h000, 32'h11);

    // irq[0] and irq[2] together: lowest index first.
    irq = 3'b101;
    idle(5);
    irq = 3'b000;
    expect_redirect(32'h200, 3'b001);
    do_commit(32'h90, F_NONE, 12'h000, 32'h0);
    drain("irq0_drain");
    rd("irq0_ucause", 12'h042, 32'h8000_0010);
    rd("irq0_uepc", 12'h041, 32'h90);
    expect_redirect(32'h90, 3'b000);
    do_commit(32'h204, F_URET, 12'h000, 32'h0);
    drain("uret3_drain");
    expect_redirect(32'h200, 3'b100);
    do_commit(32'h94, F_NONE, 12'h000, 32'h0);
    drain("irq2_drain");
    rd("irq2_ucause", 12'h042, 32'h8000_0012);
    rd("irq2_uepc", 12'h041, 32'h94);
    rd("irq2_ustatus", 12'h000, 32'h10);
    step();

    // ecall beats a pending irq[0], which stays pending.
    expect_redirect(32'h94, 3'b000);
    do_commit(32'h208, F_URET, 12'h000, 32'h0);
    drain("uret4_drain");
    irq[0] = 1'b1;
    idle(5);
    irq[0] = 1'b0;
    expect_redirect(32'h200, 3'b000);
    do_commit(32'ha0, F_ECALL, 12'h000, 32'h0);
    drain("ecall_vs_irq_drain");
    rd("ecall_vs_irq_ucause", 12'h042, 32'h8);
    rd("ecall_vs_irq_uepc", 12'h041, 32'ha0);
    rd("ecall_vs_irq_ustatus", 12'h000, 32'h10);
    step();
    do_commit(32'ha4, F_RSI, 12'h000, 32'h1);
    rd("reenable_ustatus", 12'h000, 32'h11);
    expect_redirect(32'h200, 3'b001);
    do_commit(32'ha8, F_NONE, 12'h000, 32'h0);
    drain("held_irq0_drain");
    rd("held_irq0_ucause", 12'h042, 32'h8000_0010);
    rd("held_irq0_uepc", 12'h041, 32'ha8);
    step();

    // Reset asserted while redirect is high drops outputs at once.
    do_commit(32'hb0, F_ECALL, 12'h000, 32'h0);
    rst = 1'b1;
    #1;
    check_val("midrst_redirect", 32'(redirect), 32'd0);
    check_val("midrst_flush", 32'(flush), 32'd0);
    check_val("midrst_redirect_pc", redirect_pc, 32'd0);
    rd("midrst_uepc", 12'h041, 32'h0);
    step();
    rst = 1'b0;
    idle(2);
    check_val("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Downstream consumer of the decode controller's `ecall`, `uret`, `CSRRSI`, `CSRRCI` and `CSRRW` outputs, which arrive pipelined to the commit point (MEM/WB boundary).
- Holds the user-mode trap CSRs: ustatus, utvec, uepc and ucause.
- Latches external interrupt requests and arbitrates synchronous traps against interrupts.
- Issues a registered PC redirect plus pipeline flush toward IF/ID.

Parameters:
- WIDTH, 32, datapath and CSR width.
- NUM_IRQ, 3, number of external interrupt lines.
- TVEC_RESET, 32'h0000_0200, utvec reset value.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- commit_valid  input  1  a real (non-bubble) instruction is at commit this cycle.
- commit_pc  input  WIDTH  PC of the committing instruction.
- ecall  input  1  committing instruction is ecall.
- uret  input  1  committing instruction is uret.
- CSRRW  input  1  committing instruction is csrrw.
- CSRRSI  input  1  committing instruction is csrrsi.
- CSRRCI  input  1  committing instruction is csrrci.
- csr_addr  input  12  CSR address of the committing instruction.
- csr_src  input  WIDTH  rs1 value for CSRRW; zimm zero-extended in [4:0] for CSRRSI/CSRRCI.
- irq  input  NUM_IRQ  external interrupt request lines, level, asynchronous to the pipeline flow.
- csr_rdata  output  WIDTH  old CSR value, written to rd.
- redirect  output  1  one-cycle pulse: fetch from redirect_pc.
- redirect_pc  output  WIDTH  trap vector or return address.
- flush  output  1  kill all younger in-flight instructions; equal to redirect.
- irq_ack  output  NUM_IRQ  one-hot pulse on the cycle an interrupt is taken.

Behaviour:
- CSR map:
  - 12'h000 ustatus: bit0 UIE, bit4 UPIE, all other bits read 0.
  - 12'h005 utvec.
  - 12'h041 uepc: bits[1:0] forced 0.
  - 12'h042 ucause: bit31 is the interrupt flag, low bits are the code.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset (async) values: ustatus=0, utvec=TVEC_RESET, uepc=0, ucause=0, pending=0, state=IDLE, redirect=0, redirect_pc=0, irq_ack=0.
- csr_rdata is combinational from the current csr_addr; it returns the pre-write value.
- Interrupt pending:
  - pending[i] is set on a rising edge of irq[i], detected through a 2-flop synchronizer plus an edge flop.
  - pending[i] clears only when that interrupt is taken.
  - Edges arriving while pending[i] is already set are merged.
- FSM states: IDLE, REDIRECT.
- IDLE, evaluated at each clk edge when commit_valid=1, in priority order:
  1. ecall: uepc<=commit_pc; ucause<=8; UPIE<=UIE; UIE<=0; redirect_pc<=utvec; go to REDIRECT.
  2. uret: UIE<=UPIE; UPIE<=1; redirect_pc<=uepc; go to REDIRECT.
  3. Interrupt, when UIE=1 and any pending bit is set:
     - Select the lowest index i.
     - uepc<=commit_pc; the committing instruction is NOT retired, and its CSR write is suppressed.
     - ucause<=32'h8000_0000|(16+i); UPIE<=UIE; UIE<=0.
     - Clear pending[i]; irq_ack[i]<=1; redirect_pc<=utvec; go to REDIRECT.
  4. CSR write:
     - CSRRW writes csr_src.
     - CSRRSI performs CSR|=csr_src[4:0].
     - CSRRCI performs CSR&=~csr_src[4:0].
     - A write to ustatus updates only bits 0 and 4.
- When commit_valid=0, no trap or interrupt is taken and nothing is written; pending bits are held.
- Simultaneous ecall or uret with a pending interrupt: the synchronous event wins. UIE becomes 0 (ecall) or UPIE (uret), and the interrupt is re-evaluated in a later IDLE cycle.
- An instruction that sets UIE via a CSR write makes a pending interrupt takeable from the next commit onward, never in the same cycle.
- REDIRECT:
  - redirect=flush=1 for exactly this cycle; irq_ack is cleared the cycle after it pulses.
  - All commit inputs are ignored, since that instruction is a flushed younger one.
  - Unconditionally returns to IDLE.
- Maximum latency from commit to redirect: 1 cycle. Back-to-back traps are therefore at least 2 cycles apart.
- Reset asserted mid-REDIRECT: outputs drop to 0 immediately, asynchronously.

Decomposition:
- Shared package constants: CSR addresses (USTATUS, UTVEC, UEPC, UCAUSE), ustatus bit indices, cause codes (CAUSE_ECALL=8, IRQ_CAUSE_BASE=16), FSM state encoding.
- One sub-module: irq_pending, the per-line synchronizer, edge detector, pending latch and fixed-priority encoder. It outputs any_pending and the index.

Test Plan:
- Reset: then read 12'h005 -> csr_rdata=32'h200; all other CSRs and outputs read 0.
- ecall at commit_pc=0x40 with UIE=1 -> next cycle redirect=1, redirect_pc=0x200; uepc=0x40, ucause=8, ustatus=0x10.
- uret after the ecall case -> redirect_pc=0x40; ustatus=0x11; a single-cycle redirect pulse; a commit in the REDIRECT cycle has no effect.
- irq[1] edge with UIE=0 -> no redirect. CSRRSI ustatus zimm=1 -> the following commit at 0x88 traps: ucause=0x8000_0011, uepc=0x88, irq_ack=3'b010.
- irq[0] and irq[2] edges together with UIE=1 -> irq[0] is taken first (ucause=0x8000_0010). After uret, irq[2] is taken (0x8000_0012).
- ecall and a pending irq[0] in the same commit -> ucause=8, irq[0] stays pending. CSRRCI on ustatus clears bit0 without touching UPIE.
